multicycle_arm_control: RTL

- Control unit for the multicycle ARM core that follows the single-cycle machine. It shares one memory port and one ALU across FETCH/DECODE/EXECUTE/WB states.
- Decodes `Instr[31:12]`, holds the NZCV flag register and condition-pass latch, and drives the multicycle datapath's muxes and enables.
- Adds a `mem_ready` wait-state handshake for slow memory.

---
 rtl/multicycle_arm_control.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_arm_control.sv
// rtl/multicycle_arm_control.sv - multicycle ARM control FSM with NZCV flags and mem_ready wait states
module multicycle_arm_control #(
  parameter logic       MEM_WAIT_EN = 1'b1,
  parameter logic [3:0] FLAG_RESET  = 4'b0000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_flags;
  logic        r_cond_ex;
  logic        r_nowrite;

  logic [3:0]  w_cond;
  logic [1:0]  w_op;
  logic [5:0]  w_funct;
  logic [3:0]  w_rd;
  logic        w_ready;
  logic        w_unused;

  logic        w_adr_src;
  logic        w_alu_src_a;
  logic [1:0]  w_alu_src_b;
  logic [1:0]  w_result_src;
  logic        w_alu_op;
  logic        w_ir_write;
  logic        w_next_pc;
  logic        w_reg_w;
  logic        w_mem_w;
  logic        w_branch;

  logic [1:0]  w_alu_control;
  logic [1:0]  w_flag_w;
  logic        w_nowrite;
  logic        w_cond_ex;
  logic        w_pcs;
  logic        w_n, w_z, w_c, w_v;

  assign w_cond   = Instr[19:16];
  assign w_op     = Instr[15:14];
  assign w_funct  = Instr[13:8];
  assign w_rd     = Instr[3:0];
  assign w_unused = ^Instr[7:4];
  assign w_ready  = mem_ready | ~MEM_WAIT_EN;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  // Condition pass and NoWrite are per-instruction latches: captured once, reused by later states.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_flags   <= FLAG_RESET;
      r_cond_ex <= 1'b0;
      r_nowrite <= 1'b0;
    end else begin
      if (r_state == S_DECODE) begin
        r_cond_ex <= w_cond_ex;
        r_nowrite <= 1'b0;
      end
      if (w_alu_op) begin
        r_nowrite <= w_nowrite;
        if (r_cond_ex & w_flag_w[1]) r_flags[3:2] <= ALUFlags[3:2];
        if (r_cond_ex & w_flag_w[0]) r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    w_next       = S_FETCH;
    w_adr_src    = 1'b0;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = 2'b00;
    w_result_src = 2'b00;
    w_alu_op     = 1'b0;
    w_ir_write   = 1'b0;
    w_next_pc    = 1'b0;
    w_reg_w      = 1'b0;
    w_mem_w      = 1'b0;
    w_branch     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = w_ready;
        w_next_pc    = w_ready;
        w_next       = w_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        w_alu_src_a  = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        case (w_op)
          2'b00:   w_next = w_funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_alu_src_b = 2'b01;
        w_next      = w_funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        w_next    = w_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src = 1'b1;
        w_mem_w   = 1'b1;
        w_next    = w_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        w_alu_op = 1'b1;
        w_next   = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_alu_src_b = 2'b01;
        w_alu_op    = 1'b1;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_w = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_b  = 2'b01;
        w_result_src = 2'b10;
        w_branch     = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_alu_control = 2'b00;
    w_flag_w      = 2'b00;
    w_nowrite     = 1'b0;
    if (w_alu_op) begin
      case (w_funct[4:1])
        4'b0100: begin w_alu_control = 2'b00; w_flag_w = {w_funct[0], w_funct[0]}; end
        4'b0010: begin w_alu_control = 2'b01; w_flag_w = {w_funct[0], w_funct[0]}; end
        4'b0000: begin w_alu_control = 2'b10; w_flag_w = {w_funct[0], 1'b0};       end
        4'b1100: begin w_alu_control = 2'b11; w_flag_w = {w_funct[0], 1'b0};       end
        4'b1010: begin
          w_alu_control = 2'b01;
          w_flag_w      = {w_funct[0], w_funct[0]};
          w_nowrite     = 1'b1;
        end
        default: w_nowrite = 1'b1;
      endcase
    end
  end

  assign {w_n, w_z, w_c, w_v} = r_flags;

  always_comb begin
    w_cond_ex = 1'b1;
    case (w_cond)
      4'b0000: w_cond_ex = w_z;
      4'b0001: w_cond_ex = ~w_z;
      4'b0010: w_cond_ex = w_c;
      4'b0011: w_cond_ex = ~w_c;
      4'b0100: w_cond_ex = w_n;
      4'b0101: w_cond_ex = ~w_n;
      4'b0110: w_cond_ex = w_v;
      4'b0111: w_cond_ex = ~w_v;
      4'b1000: w_cond_ex = w_c & ~w_z;
      4'b1001: w_cond_ex = ~w_c | w_z;
      4'b1010: w_cond_ex = (w_n == w_v);
      4'b1011: w_cond_ex = (w_n != w_v);
      4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
      4'b1101: w_cond_ex = w_z | (w_n != w_v);
      default: w_cond_ex = 1'b1;
    endcase
  end

  // Write enables are masked directly by reset so a stalled store drops without a clock edge.
  assign w_pcs      = ((w_rd == 4'hF) & w_reg_w) | w_branch;
  assign PCWrite    = ~reset & (w_next_pc | (w_pcs & r_cond_ex));
  assign RegWrite   = ~reset & w_reg_w & r_cond_ex & ~r_nowrite;
  assign MemWrite   = ~reset & w_mem_w & r_cond_ex;
  assign IRWrite    = ~reset & w_ir_write;
  assign AdrSrc     = w_adr_src;
  assign ALUSrcA    = w_alu_src_a;
  assign ALUSrcB    = w_alu_src_b;
  assign ResultSrc  = w_result_src;
  assign ALUControl = w_alu_control;
  assign ImmSrc     = w_op;
  assign RegSrc     = {w_op == 2'b01, w_op == 2'b10};
  assign state      = r_state;

endmodule
